vram_scroll: RTL and testbench



---
 rtl/vram_pkg.sv | 17 +
 rtl/vram_dp.sv | 30 +++
 rtl/vram_scroll.sv | 174 +++++++++++++++++
 tb/tb_vram_scroll.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and helpers for the scrolling text-mode video RAM.
package vram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLR_LINE,
    CLR_ALL
  } state_t;

  localparam logic [5:0] BLANK_DEF = 6'b100000;

  // Index width for a range of n entries, never less than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vram_dp.sv
// Simple dual-port RAM: one write port, one registered read port.
module vram_dp
  import vram_pkg::*;
#(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned DEPTH  = 960
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [idx_w(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      re,
  input  logic [idx_w(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds its value between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vram_scroll.sv
// Text-mode video RAM with cursor writes, circular-row hardware scroll and a
// clear sequencer sharing the single RAM write port.
module vram_scroll
  import vram_pkg::*;
#(
  parameter int unsigned        DATA_W     = 6,
  parameter int unsigned        COLS       = 40,
  parameter int unsigned        ROWS       = 24,
  parameter logic [DATA_W-1:0]  BLANK      = DATA_W'(BLANK_DEF),
  parameter bit                 INIT_CLEAR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     wr_cmd,
  input  logic [DATA_W-1:0]        wr_char,
  input  logic                     clr_req,
  input  logic                     rd_en,
  input  logic [idx_w(ROWS)-1:0]   rd_row,
  input  logic [idx_w(COLS)-1:0]   rd_col,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [idx_w(ROWS)-1:0]   cur_row,
  output logic [idx_w(COLS)-1:0]   cur_col,
  output logic                     busy
);

  localparam int unsigned RW    = idx_w(ROWS);
  localparam int unsigned CW    = idx_w(COLS);
  localparam int unsigned DEPTH = ROWS * COLS;
  localparam int unsigned AW    = idx_w(DEPTH);

  // Logical row to physical row through the circular base offset.
  function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] lrow,
                                             input logic [RW-1:0] b);
    logic [RW:0] s;
    s = {1'b0, lrow} + {1'b0, b};
    if (s >= (RW+1)'(ROWS)) s = s - (RW+1)'(ROWS);
    return s[RW-1:0];
  endfunction

  function automatic logic [AW-1:0] map_addr(input logic [RW-1:0] prow,
                                             input logic [CW-1:0] col);
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  state_t         state, state_n;
  logic [RW-1:0]  cur_row_n, base, base_n, clr_row, clr_row_n;
  logic [CW-1:0]  cur_col_n;
  logic [AW-1:0]  clr_cnt, clr_cnt_n;
  logic           clr_pend, clr_pend_n;
  logic           nl;
  logic           we;
  logic [AW-1:0]  waddr;
  logic [DATA_W-1:0] wdata;

  assign busy     = (state != IDLE);
  assign wr_ready = (state == IDLE) && !clr_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT_CLEAR ? CLR_ALL : IDLE;
      cur_row  <= '0;
      cur_col  <= '0;
      base     <= '0;
      clr_row  <= '0;
      clr_cnt  <= '0;
      clr_pend <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_n;
      cur_row  <= cur_row_n;
      cur_col  <= cur_col_n;
      base     <= base_n;
      clr_row  <= clr_row_n;
      clr_cnt  <= clr_cnt_n;
      clr_pend <= clr_pend_n;
      rd_valid <= rd_en;
    end
  end

  always_comb begin
    state_n    = state;
    cur_row_n  = cur_row;
    cur_col_n  = cur_col;
    base_n     = base;
    clr_row_n  = clr_row;
    clr_cnt_n  = clr_cnt;
    clr_pend_n = clr_pend;
    nl         = 1'b0;
    we         = 1'b0;
    waddr      = map_addr(phys_row(cur_row, base), cur_col);
    wdata      = wr_char;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_n   = CLR_ALL;
          cur_row_n = '0;
          cur_col_n = '0;
          base_n    = '0;
          clr_cnt_n = '0;
        end else if (wr_valid) begin
          if (!wr_cmd) begin
            we = 1'b1;
            if (cur_col < CW'(COLS-1)) cur_col_n = cur_col + 1'b1;
            else                       nl = 1'b1;
          end else begin
            nl = 1'b1;
          end
        end
        // Newline at the bottom row scrolls: the old top row becomes the new bottom.
        if (nl) begin
          cur_col_n = '0;
          if (cur_row < RW'(ROWS-1)) begin
            cur_row_n = cur_row + 1'b1;
          end else begin
            base_n    = (base == RW'(ROWS-1)) ? '0 : base + 1'b1;
            clr_row_n = base;
            clr_cnt_n = '0;
            state_n   = CLR_LINE;
          end
        end
      end
      CLR_LINE: begin
        we    = 1'b1;
        waddr = map_addr(clr_row, CW'(clr_cnt));
        wdata = BLANK;
        if (clr_req) clr_pend_n = 1'b1;
        if (clr_cnt == AW'(COLS-1)) begin
          clr_cnt_n = '0;
          if (clr_pend || clr_req) begin
            state_n    = CLR_ALL;
            clr_pend_n = 1'b0;
            cur_row_n  = '0;
            cur_col_n  = '0;
            base_n     = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end
      CLR_ALL: begin
        we    = 1'b1;
        waddr = clr_cnt;
        wdata = BLANK;
        if (clr_cnt == AW'(DEPTH-1)) begin
          clr_cnt_n = '0;
          state_n   = IDLE;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  vram_dp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (map_addr(phys_row(rd_row, base), rd_col)),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_vram_scroll.sv
// Bench for vram_scroll: directed vectors plus random traffic against a
// logical-screen model that scrolls by shifting rows.
module tb_vram_scroll;

  localparam int ROWS = 24;
  localparam int COLS = 40;
  localparam logic [5:0] BLANK = 6'b100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_cmd = 1'b0;
  logic [5:0] wr_char = '0;
  logic       clr_req = 1'b0;
  logic       rd_en = 1'b0;
  logic [4:0] rd_row = '0;
  logic [5:0] rd_col = '0;
  logic [5:0] rd_data;
  logic       rd_valid;
  logic [4:0] cur_row;
  logic [5:0] cur_col;
  logic       busy;

  vram_scroll dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_cmd   (wr_cmd),
    .wr_char  (wr_char),
    .clr_req  (clr_req),
    .rd_en    (rd_en),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: screen in logical coordinates; scrolling moves rows up.
  logic [5:0] scr [ROWS][COLS];
  int mrow = 0;
  int mcol = 0;

  typedef struct {
    bit         cmd;
    logic [5:0] ch;
    int         erow;
    int         ecol;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_blank();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = BLANK;
    mrow = 0;
    mcol = 0;
  endtask

  task automatic model_nl(output bit scrolled);
    scrolled = 1'b0;
    mcol = 0;
    if (mrow < ROWS-1) mrow++;
    else begin
      for (int r = 0; r < ROWS-1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r+1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = BLANK;
      scrolled = 1'b1;
    end
  endtask

  // Counts consecutive busy samples; optionally pulses clr_req at sample pulse_at.
  task automatic count_busy(input int pulse_at, output int n);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      clr_req = (n == pulse_at);
      @(posedge clk); #1;
    end
    clr_req = 1'b0;
  endtask

  task automatic put(input bit cmd, input logic [5:0] ch);
    int n;
    bit sc;
    n = 0;
    while (!wr_ready && n < 3000) begin
      n++;
      @(posedge clk); #1;
    end
    if (!wr_ready) chk("ready_timeout", int'(wr_ready), 1);
    wr_valid = 1'b1;
    wr_cmd   = cmd;
    wr_char  = ch;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    sc = 1'b0;
    if (!cmd) begin
      scr[mrow][mcol] = ch;
      if (mcol < COLS-1) mcol++;
      else model_nl(sc);
    end else begin
      model_nl(sc);
    end
    if (sc) begin
      count_busy(-1, n);
      chk("scroll_busy_len", n, COLS);
    end
  endtask

  task automatic read_chk(input int r, input int c);
    rd_en  = 1'b1;
    rd_row = 5'(r);
    rd_col = 6'(c);
    @(posedge clk); #1;
    rd_en = 1'b0;
    chk("rd_valid", int'(rd_valid), 1);
    chk($sformatf("rd_data(%0d,%0d)", r, c), int'(rd_data), int'(scr[r][c]));
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_row"}, int'(cur_row), mrow);
    chk({tag, "_col"}, int'(cur_col), mcol);
  endtask

  task automatic chk_row(input int r);
    for (int c = 0; c < COLS; c++) read_chk(r, c);
  endtask

  initial begin
    int n;
    logic [5:0] held;

    vecs[0] = '{1'b0, 6'h0a, 0, 1};
    vecs[1] = '{1'b1, 6'h00, 1, 0};
    vecs[2] = '{1'b0, 6'h0b, 1, 1};
    vecs[3] = '{1'b1, 6'h15, 2, 0};
    vecs[4] = '{1'b1, 6'h00, 3, 0};
    vecs[5] = '{1'b0, 6'h3f, 3, 1};

    // Reset values
    #22;
    chk("rst_busy", int'(busy), 1);
    chk("rst_ready", int'(wr_ready), 0);
    chk("rst_cur_row", int'(cur_row), 0);
    chk("rst_cur_col", int'(cur_col), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Power-up clear
    count_busy(-1, n);
    chk("init_clear_len", n, ROWS*COLS);
    chk("init_ready", int'(wr_ready), 1);
    model_blank();
    read_chk(0, 0);
    read_chk(23, 39);
    read_chk(12, 17);

    // Single character, then read-back latency and hold
    put(1'b0, 6'h01);
    chk_cursor("c1");
    read_chk(0, 0);
    held = rd_data;
    @(posedge clk); #1;
    chk("rd_valid_drop", int'(rd_valid), 0);
    chk("rd_data_hold", int'(rd_data), int'(held));

    // A full row of characters wraps without scrolling
    for (int i = 0; i < COLS; i++) begin
      put(1'b0, 6'h02);
      chk("no_busy_wrap", int'(busy), 0);
    end
    chk_cursor("row_wrap");
    chk_row(0);

    // Newlines down to the bottom and one scroll
    put(1'b0, 6'h03);
    while (mrow < ROWS-1) put(1'b1, 6'h00);
    put(1'b1, 6'h00);
    chk_cursor("scroll");
    chk_row(0);
    chk_row(1);
    chk_row(ROWS-1);

    // Clear request with a simultaneous write; later request in CLR_ALL ignored
    clr_req  = 1'b1;
    wr_valid = 1'b1;
    wr_cmd   = 1'b0;
    wr_char  = 6'h2a;
    #1;
    chk("clr_blocks_ready", int'(wr_ready), 0);
    @(posedge clk); #1;
    clr_req  = 1'b0;
    wr_valid = 1'b0;
    count_busy(100, n);
    chk("clr_all_len", n, ROWS*COLS);
    model_blank();
    chk_cursor("clr");
    chk_row(0);

    // Table-driven cursor vectors
    for (int i = 0; i < 6; i++) begin
      put(vecs[i].cmd, vecs[i].ch);
      chk($sformatf("vec%0d_row", i), int'(cur_row), vecs[i].erow);
      chk($sformatf("vec%0d_col", i), int'(cur_col), vecs[i].ecol);
    end
    chk_row(1);
    chk_row(3);

    // Clear request during a line clear chains into a full clear
    while (mrow < ROWS-1) put(1'b1, 6'h00);
    wr_valid = 1'b1;
    wr_cmd   = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    count_busy(5, n);
    chk("line_then_all_len", n, COLS + ROWS*COLS);
    model_blank();
    chk_cursor("pend_clr");
    chk_row(ROWS-1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) put(1'b1, 6'h00);
      else put(1'b0, 6'($urandom));
      chk_cursor("rnd");
      if ((i % 16) == 0) read_chk($urandom_range(0, ROWS-1), $urandom_range(0, COLS-1));
    end
    for (int r = 0; r < ROWS; r++) chk_row(r);

    // Reset in the middle of a clear restarts it from the beginning
    put(1'b0, 6'h11);
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("mid_rst_busy", int'(busy), 1);
    chk("mid_rst_rd_valid", int'(rd_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(-1, n);
    chk("restart_clear_len", n, ROWS*COLS);
    model_blank();
    chk_cursor("post_rst");
    read_chk(0, 0);
    read_chk(23, 39);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
